// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage issuing one load/store at a time to memoryController.
module mem_access_stage #(
    parameter int DATA_W = 192,
    parameter int SCALAR_W = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W = 5,
    parameter int unsigned RAM_BASE = 31000,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_we,
    input  logic              ex_vecop,
    input  logic [ADDR_W-1:0] ex_address,
    input  logic [DATA_W-1:0] ex_wd,
    input  logic [TAG_W-1:0]  ex_tag,
    output logic              mc_we,
    output logic              mc_vecop,
    output logic [ADDR_W-1:0] mc_address,
    output logic [DATA_W-1:0] mc_wd,
    input  logic [DATA_W-1:0] mc_rd,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [TAG_W-1:0]  wb_tag,
    output logic              fault,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int CNT_W = RD_LATENCY > 1 ? $clog2(RD_LATENCY) : 1;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic lat_we, hs, bad_store;
    assign ex_ready = state == IDLE;
    assign busy = state != IDLE;
    assign wb_valid = state == RESP;
    assign mc_we = state == ISSUE && lat_we;
    assign hs = ex_valid && ex_ready;
    assign bad_store = ex_we && ex_address < ADDR_W'(RAM_BASE);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = hs && !bad_store ? ISSUE : IDLE;
            ISSUE: state_nx = lat_we ? IDLE : WAIT;
            WAIT:  state_nx = cnt == '0 ? RESP : WAIT;
            RESP:  state_nx = wb_ready ? IDLE : RESP;
        endcase
    end
    // Faulting stores are not latched so the memory-side outputs keep their last values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we <= 1'b0;
            mc_vecop <= 1'b0;
            mc_address <= '0;
            mc_wd <= '0;
            wb_tag <= '0;
            wb_data <= '0;
            cnt <= '0;
            fault <= 1'b0;
        end else begin
            fault <= hs && bad_store;
            if (hs && !bad_store) begin
                lat_we <= ex_we;
                mc_vecop <= ex_vecop;
                mc_address <= ex_address;
                mc_wd <= ex_vecop ? ex_wd : DATA_W'(ex_wd[SCALAR_W-1:0]);
                wb_tag <= ex_tag;
            end
            if (state == ISSUE) cnt <= CNT_W'(RD_LATENCY - 1);
            else if (state == WAIT) cnt <= cnt - 1'b1;
            if (state == WAIT && cnt == '0)
                wb_data <= mc_vecop ? mc_rd : DATA_W'(mc_rd[SCALAR_W-1:0]);
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed scoreboard bench for mem_access_stage at read latency 1 and 3.
module tb_mem_access_stage;
    logic clk = 0, rst = 0;
    logic ex_valid = 0, ex_valid2 = 0, ex_we = 0, ex_vecop = 0, wb_ready = 1;
    logic [31:0] ex_address = 0;
    logic [191:0] ex_wd = 0, mc_rd = 0;
    logic [4:0] ex_tag = 0;
    logic ex_ready, mc_we, mc_vecop, wb_valid, fault, busy;
    logic [31:0] mc_address;
    logic [191:0] mc_wd, wb_data;
    logic [4:0] wb_tag;
    logic ex_ready2, mc_we2, mc_vecop2, wb_valid2, fault2, busy2;
    logic [31:0] mc_address2;
    logic [191:0] mc_wd2, wb_data2;
    logic [4:0] wb_tag2;
    typedef struct {logic [191:0] d; logic [4:0] t;} exp_t;
    exp_t q1[$], q2[$];
    exp_t e;
    int n_checks = 0, n_fail = 0, we_cnt = 0, w0;
    localparam logic [191:0] V = {64'hDEADBEEF_CAFEF00D, 64'h01234567_89ABCDEF, 64'd1234567891123};
    localparam logic [191:0] V2 = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC};

    mem_access_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_we(ex_we),
        .ex_vecop(ex_vecop), .ex_address(ex_address), .ex_wd(ex_wd), .ex_tag(ex_tag),
        .mc_we(mc_we), .mc_vecop(mc_vecop), .mc_address(mc_address), .mc_wd(mc_wd),
        .mc_rd(mc_rd), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_tag(wb_tag), .fault(fault), .busy(busy));

    mem_access_stage #(.RD_LATENCY(3)) dut2 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid2), .ex_ready(ex_ready2), .ex_we(ex_we),
        .ex_vecop(ex_vecop), .ex_address(ex_address), .ex_wd(ex_wd), .ex_tag(ex_tag),
        .mc_we(mc_we2), .mc_vecop(mc_vecop2), .mc_address(mc_address2), .mc_wd(mc_wd2),
        .mc_rd(mc_rd), .wb_valid(wb_valid2), .wb_ready(wb_ready), .wb_data(wb_data2),
        .wb_tag(wb_tag2), .fault(fault2), .busy(busy2));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit second, input logic we, input logic vec, input logic [31:0] a,
                        input logic [191:0] wd, input logic [4:0] tag);
        int n = 0;
        while (!(second ? ex_ready2 : ex_ready) && n < 50) begin
            tick;
            n++;
        end
        check("ex_ready before issue", second ? ex_ready2 : ex_ready, 1);
        ex_we = we; ex_vecop = vec; ex_address = a; ex_wd = wd; ex_tag = tag;
        if (second) ex_valid2 = 1; else ex_valid = 1;
        tick;
        ex_valid = 0;
        ex_valid2 = 0;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (mc_we) we_cnt++;
                    if (wb_valid && wb_ready) begin
                        if (q1.size() == 0) check("wb unexpected valid", wb_valid, 0);
                        else begin
                            e = q1.pop_front();
                            check("wb_data", wb_data, e.d);
                            check("wb_tag", wb_tag, 192'(e.t));
                        end
                    end
                    if (wb_valid2 && wb_ready) begin
                        if (q2.size() == 0) check("wb2 unexpected valid", wb_valid2, 0);
                        else begin
                            e = q2.pop_front();
                            check("wb2_data", wb_data2, e.d);
                            check("wb2_tag", wb_tag2, 192'(e.t));
                        end
                    end
                end
            end
            begin
                #100000;
                $display("FAIL global timeout");
                $fatal(1, "timeout");
            end
            begin
                #1 rst = 1;
                #11;
                check("rst ex_ready", ex_ready, 1);
                check("rst mc_we", mc_we, 0);
                check("rst busy", busy, 0);
                check("rst wb_valid", wb_valid, 0);
                check("rst fault", fault, 0);
                check("rst mc_address", mc_address, 0);
                check("rst wb_data", wb_data, 0);
                @(negedge clk) rst = 0;
                tick;
                // scalar store: upper wd bits must be dropped
                w0 = we_cnt;
                send(0, 1, 0, 31000, {160'h5A5A, 32'd3}, 0);
                check("st mc_we", mc_we, 1);
                check("st mc_address", mc_address, 31000);
                check("st mc_wd", mc_wd, 3);
                check("st wb_valid", wb_valid, 0);
                check("st ex_ready busy", ex_ready, 0);
                tick;
                check("st mc_we drop", mc_we, 0);
                check("st ex_ready back", ex_ready, 1);
                check("st we pulses", we_cnt - w0, 1);
                // scalar load latency 1
                mc_rd = {{144{1'b1}}, 48'hFFFF_0000_0003};
                q1.push_back('{192'd3, 5'd7});
                send(0, 0, 0, 31000, 0, 7);
                check("ld c1 wb_valid", wb_valid, 0);
                check("ld c1 mc_we", mc_we, 0);
                tick;
                check("ld c2 wb_valid", wb_valid, 0);
                tick;
                check("ld c3 wb_valid", wb_valid, 1);
                tick;
                check("ld c4 ex_ready", ex_ready, 1);
                // vector store then load
                send(0, 1, 1, 31005, 192'd1234567891123, 0);
                check("vst mc_vecop", mc_vecop, 1);
                check("vst mc_wd", mc_wd, 192'd1234567891123);
                check("vst mc_we", mc_we, 1);
                tick;
                mc_rd = V;
                q1.push_back('{V, 5'd9});
                send(0, 0, 1, 31005, 0, 9);
                tick;
                check("vld wait mc_vecop", mc_vecop, 1);
                check("vld wait mc_address", mc_address, 31005);
                check("vld wait mc_we", mc_we, 0);
                tick;
                check("vld wb_valid", wb_valid, 1);
                tick;
                // illegal stores, back-to-back with a legal one
                w0 = we_cnt;
                send(0, 1, 0, 1000, 1, 0);
                check("ill1000 fault", fault, 1);
                check("ill1000 ex_ready", ex_ready, 1);
                send(0, 1, 0, 30999, 1, 0);
                check("ill30999 fault", fault, 1);
                check("ill30999 mc_we", mc_we, 0);
                send(0, 1, 0, 31000, 1, 0);
                check("legal fault", fault, 0);
                check("legal mc_we", mc_we, 1);
                tick;
                check("ill we pulses", we_cnt - w0, 1);
                // backpressure
                wb_ready = 0;
                mc_rd = V;
                q1.push_back('{V, 5'd3});
                send(0, 0, 1, 31005, 0, 3);
                tick;
                tick;
                mc_rd = ~V;
                for (int i = 0; i < 5; i++) begin
                    check("bp wb_valid", wb_valid, 1);
                    check("bp wb_data", wb_data, V);
                    check("bp ex_ready", ex_ready, 0);
                    tick;
                end
                wb_ready = 1;
                tick;
                check("bp release ex_ready", ex_ready, 1);
                check("bp release wb_valid", wb_valid, 0);
                // reset during WAIT drops the load
                send(0, 0, 0, 31000, 0, 4);
                tick;
                check("wait busy", busy, 1);
                #1 rst = 1;
                #1;
                check("rstw busy", busy, 0);
                check("rstw ex_ready", ex_ready, 1);
                check("rstw mc_address", mc_address, 0);
                #1 rst = 0;
                tick;
                // reset during ISSUE of a store
                send(0, 1, 0, 31000, 5, 0);
                check("rsti pre mc_we", mc_we, 1);
                #1 rst = 1;
                #1;
                check("rsti mc_we", mc_we, 0);
                check("rsti mc_wd", mc_wd, 0);
                check("rsti busy", busy, 0);
                #1 rst = 0;
                tick;
                mc_rd = {160'hFFFF, 32'hABCD1234};
                q1.push_back('{192'hABCD1234, 5'd2});
                send(0, 0, 0, 31100, 0, 2);
                tick;
                tick;
                check("post rst wb_valid", wb_valid, 1);
                tick;
                // latency 3 instance
                mc_rd = V2;
                q2.push_back('{192'h9999_AAAA_BBBB_CCCC & 192'hFFFF_FFFF, 5'd11});
                send(1, 0, 0, 31000, 0, 11);
                for (int i = 1; i < 5; i++) begin
                    check("lat3 early wb_valid", wb_valid2, 0);
                    tick;
                end
                check("lat3 c5 wb_valid", wb_valid2, 1);
                tick;
                check("q1 drained", 192'(q1.size()), 0);
                check("q2 drained", 192'(q2.size()), 0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        join
    end
endmodule
